// File: rtl/note_sequencer.sv
// note_sequencer: plays a RAM note table (pitch divider + duration in sample ticks) in order,
// driving the sine clkgen divider and a note gate. Define SEQ_TEMPO_EN to add tempo_shift scaling.
module note_sequencer #(
  parameter int DEPTH     = 32,
  parameter int PW        = 5,
  parameter int DW        = 13,
  parameter int GAP_TICKS = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [PW-1:0] wr_pitch,
  input  logic [DW-1:0] wr_dur,
  input  logic [AW:0]   seq_len,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  input  logic          tick,
`ifdef SEQ_TEMPO_EN
  input  logic [1:0]    tempo_shift,
`endif
  output logic [PW-1:0] pitch_o,
  output logic          note_on,
  output logic [AW-1:0] note_idx,
  output logic          busy,
  output logic          done
);

`ifdef SEQ_TEMPO_EN
  localparam int CW = DW + 3;
`else
  localparam int CW = DW;
`endif
  localparam int            GW       = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int            GAP_MAX  = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX);
  localparam logic [AW:0]   DEPTH_W  = DEPTH[AW:0];
  localparam logic          HAS_GAP  = (GAP_TICKS > 0);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

  logic [PW-1:0] pitch_mem [DEPTH];
  logic [DW-1:0] dur_mem   [DEPTH];

  state_t        state, state_next;
  logic [AW:0]   len, len_m1;
  logic [AW-1:0] idx;
  logic [CW-1:0] dur_cnt, eff_dur, fetch_eff;
  logic [DW-1:0] fetch_dur;
  logic [GW-1:0] gap_cnt;
  logic          note_end, advance, finish, last_note, abort;

  // Table write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pitch_mem[wr_addr] <= wr_pitch;
      dur_mem[wr_addr]   <= wr_dur;
    end
  end

  assign len_m1    = len - {{AW{1'b0}}, 1'b1};
  assign last_note = ({1'b0, idx} == len_m1);
  // start/stop are single-cycle strobes with no ready: start is dropped unless IDLE, stop always wins.
  assign abort     = stop && (state != IDLE);
  assign fetch_dur = dur_mem[idx];

  always_comb begin
    fetch_eff = (fetch_dur == '0) ? CW'(1) : CW'(fetch_dur);
`ifdef SEQ_TEMPO_EN
    fetch_eff = fetch_eff << tempo_shift;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    note_end   = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE:  if (start && !stop && seq_len != '0) state_next = FETCH;
      FETCH: state_next = PLAY;
      PLAY: begin
        if (tick && dur_cnt == eff_dur - CW'(1)) begin
          note_end = 1'b1;
          if (HAS_GAP) state_next = GAP;
          else         advance    = 1'b1;
        end
      end
      GAP:   if (tick && gap_cnt == GAP_LAST) advance = 1'b1;
      default: state_next = IDLE;
    endcase
    if (advance) begin
      if (!last_note || loop) begin
        state_next = FETCH;
      end else begin
        state_next = IDLE;
        finish     = 1'b1;
      end
    end
    if (abort) begin
      state_next = IDLE;
      finish     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len     <= '0;
      idx     <= '0;
      pitch_o <= '0;
      note_on <= 1'b0;
      done    <= 1'b0;
      dur_cnt <= '0;
      eff_dur <= '0;
      gap_cnt <= '0;
    end else begin
      done <= finish;
      case (state)
        IDLE: begin
          if (state_next == FETCH) begin
            len <= (seq_len > DEPTH_W) ? DEPTH_W : seq_len;
            idx <= '0;
          end
        end
        // The table read lands directly in the output/duration registers (1-cycle read).
        FETCH: begin
          if (!abort) begin
            pitch_o <= pitch_mem[idx];
            note_on <= (pitch_mem[idx] != '0);
            dur_cnt <= '0;
            eff_dur <= fetch_eff;
          end
        end
        PLAY: begin
          if (tick) dur_cnt <= dur_cnt + CW'(1);
          if (note_end) begin
            note_on <= 1'b0;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (tick) gap_cnt <= gap_cnt + GW'(1);
        end
        default: ;
      endcase
      if (advance && state_next == FETCH) idx <= last_note ? '0 : idx + AW'(1);
      if (abort) note_on <= 1'b0;
    end
  end

  assign note_idx = idx;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a legato instance (no gap) and a 2-tick-gap instance share all inputs.
module tb_note_sequencer;
  localparam int AW = 5;
  localparam int PW = 5;
  localparam int DW = 13;

  logic          clk = 1'b0;
  logic          reset, wr_en, loop, start, stop, tick;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_pitch;
  logic [DW-1:0] wr_dur;
  logic [AW:0]   seq_len;

  logic [PW-1:0] pitch_a, pitch_b;
  logic [AW-1:0] idx_a, idx_b;
  logic          note_on_a, note_on_b, busy_a, busy_b, done_a, done_b;

  int checks = 0;
  int errors = 0;
  int dcnt_a = 0;
  int dcnt_b = 0;

  always #5 clk = ~clk;

  note_sequencer #(.DEPTH(32), .PW(PW), .DW(DW), .GAP_TICKS(0)) u_legato (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_pitch(wr_pitch),
    .wr_dur(wr_dur), .seq_len(seq_len), .loop(loop), .start(start), .stop(stop), .tick(tick),
`ifdef SEQ_TEMPO_EN
    .tempo_shift(2'd0),
`endif
    .pitch_o(pitch_a), .note_on(note_on_a), .note_idx(idx_a), .busy(busy_a), .done(done_a)
  );

  note_sequencer #(.DEPTH(32), .PW(PW), .DW(DW), .GAP_TICKS(2)) u_gap (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_pitch(wr_pitch),
    .wr_dur(wr_dur), .seq_len(seq_len), .loop(loop), .start(start), .stop(stop), .tick(tick),
`ifdef SEQ_TEMPO_EN
    .tempo_shift(2'd0),
`endif
    .pitch_o(pitch_b), .note_on(note_on_b), .note_idx(idx_b), .busy(busy_b), .done(done_b)
  );

  always @(negedge clk) begin
    if (done_a === 1'b1) dcnt_a++;
    if (done_b === 1'b1) dcnt_b++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [PW-1:0] p, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_pitch = p; wr_dur = d;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(3);
    end
  endtask

  task automatic go(input logic [AW:0] n, input logic lp);
    seq_len = n; loop = lp; start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(1); stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_pitch = '0; wr_dur = '0;
    seq_len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    cyc(2);
    chk("rst_pitch", 32'(pitch_a), 0);
    chk("rst_note_on", 32'(note_on_a), 0);
    chk("rst_idx", 32'(idx_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    reset = 1'b0;
    cyc(1);

    wr(5'd0, 5'd18, 13'd4);
    wr(5'd1, 5'd13, 13'd2);
    wr(5'd2, 5'd0, 13'd3);

    // one-shot sequence
    go(6'd3, 1'b0);
    chk("t1_fetch_busy", 32'(busy_a), 1);
    cyc(1);
    chk("t1_e0_pitch", 32'(pitch_a), 18);
    chk("t1_e0_on", 32'(note_on_a), 1);
    ticks(3);
    chk("t1_e0_hold_on", 32'(note_on_a), 1);
    chk("t1_e0_hold_pitch", 32'(pitch_a), 18);
    ticks(1);
    chk("t1_e1_pitch", 32'(pitch_a), 13);
    chk("t1_e1_idx", 32'(idx_a), 1);
    chk("t1_e1_on", 32'(note_on_a), 1);
    chk("t1_gap_on", 32'(note_on_b), 0);
    chk("t1_gap_pitch", 32'(pitch_b), 18);
    chk("t1_gap_busy", 32'(busy_b), 1);
    ticks(1);
    chk("t1_e1_still", 32'(pitch_a), 13);
    ticks(1);
    chk("t1_e2_pitch", 32'(pitch_a), 0);
    chk("t1_e2_on", 32'(note_on_a), 0);
    chk("t1_e2_idx", 32'(idx_a), 2);
    ticks(2);
    chk("t1_e2_busy", 32'(busy_a), 1);
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("t1_done", 32'(done_a), 1);
    chk("t1_busy_fall", 32'(busy_a), 0);
    cyc(1);
    chk("t1_done_pulse", 32'(done_a), 0);
    cyc(2);
    chk("t1_done_count", 32'(dcnt_a), 1);
    pulse_stop();
    chk("t1_gap_stopped", 32'(busy_b), 0);

    // looping sequence
    go(6'd3, 1'b1);
    cyc(1);
    ticks(4);
    chk("t2_gap_on", 32'(note_on_b), 0);
    chk("t2_gap_idx", 32'(idx_b), 0);
    ticks(2);
    chk("t2_gap_e1_pitch", 32'(pitch_b), 13);
    chk("t2_gap_e1_on", 32'(note_on_b), 1);
    ticks(3);
    chk("t2_leg_wrap_idx", 32'(idx_a), 0);
    chk("t2_leg_wrap_pitch", 32'(pitch_a), 18);
    ticks(6);
    chk("t2_gap_wrap_idx", 32'(idx_b), 0);
    chk("t2_gap_wrap_pitch", 32'(pitch_b), 18);
    chk("t2_gap_wrap_on", 32'(note_on_b), 1);
    chk("t2_leg_e2_idx", 32'(idx_a), 2);
    chk("t2_no_done", 32'(dcnt_b), 0);

    // stop mid-note at tick 2 of 4
    ticks(2);
    chk("t3_pre_stop_on", 32'(note_on_b), 1);
    pulse_stop();
    chk("t3_stop_busy", 32'(busy_b), 0);
    chk("t3_stop_on", 32'(note_on_b), 0);
    chk("t3_stop_done", 32'(done_b), 0);
    chk("t3_stop_busy_leg", 32'(busy_a), 0);
    cyc(2);
    chk("t3_stop_done_cnt", 32'(dcnt_a), 1);

    // stop and start together while playing
    go(6'd3, 1'b0);
    cyc(1);
    stop = 1'b1; start = 1'b1; cyc(1); stop = 1'b0; start = 1'b0;
    chk("t4_ss_busy", 32'(busy_a), 0);
    cyc(1);
    chk("t4_ss_busy_after", 32'(busy_a), 0);

    // zero-length start
    go(6'd0, 1'b0);
    chk("t5_len0_busy", 32'(busy_a), 0);
    cyc(2);
    chk("t5_len0_busy2", 32'(busy_a), 0);
    chk("t5_len0_done_cnt", 32'(dcnt_a), 1);

    // zero duration plays one tick
    wr(5'd0, 5'd7, 13'd0);
    go(6'd1, 1'b0);
    cyc(1);
    chk("t6_dur0_pitch", 32'(pitch_a), 7);
    chk("t6_dur0_on", 32'(note_on_a), 1);
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("t6_dur0_done", 32'(done_a), 1);
    chk("t6_dur0_off", 32'(note_on_a), 0);
    chk("t6_gap_busy", 32'(busy_b), 1);
    chk("t6_gap_off", 32'(note_on_b), 0);
    cyc(3);
    ticks(2);
    chk("t6_gap_done_cnt", 32'(dcnt_b), 1);
    chk("t6_gap_idle", 32'(busy_b), 0);

    // seq_len beyond DEPTH clamps to 32 entries
    wr(5'd0, 5'd18, 13'd4);
    for (int i = 3; i < 32; i++) wr(i[4:0], i[4:0], 13'd1);
    go(6'd40, 1'b0);
    cyc(1);
    ticks(37);
    chk("t7_last_idx", 32'(idx_a), 31);
    chk("t7_last_pitch", 32'(pitch_a), 31);
    chk("t7_last_busy", 32'(busy_a), 1);
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("t7_done", 32'(done_a), 1);
    chk("t7_idle", 32'(busy_a), 0);
    pulse_stop();

    // reset during gap, then table survives
    go(6'd3, 1'b0);
    cyc(1);
    ticks(4);
    chk("t8_in_gap", 32'(busy_b), 1);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk("t8_rst_pitch", 32'(pitch_b), 0);
    chk("t8_rst_on", 32'(note_on_b), 0);
    chk("t8_rst_idx", 32'(idx_b), 0);
    chk("t8_rst_busy", 32'(busy_b), 0);
    chk("t8_rst_done", 32'(done_b), 0);
    chk("t8_rst_pitch_leg", 32'(pitch_a), 0);
    go(6'd3, 1'b0);
    cyc(1);
    chk("t8_replay_pitch", 32'(pitch_b), 18);
    chk("t8_replay_on", 32'(note_on_b), 1);
    pulse_stop();

    // writes while playing
    go(6'd2, 1'b0);
    wr(5'd0, 5'd25, 13'd5);
    chk("t9_e0_old_pitch", 32'(pitch_a), 18);
    wr(5'd1, 5'd20, 13'd1);
    ticks(4);
    chk("t9_e1_new_pitch", 32'(pitch_a), 20);
    chk("t9_e1_idx", 32'(idx_a), 1);
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("t9_done", 32'(done_a), 1);
    pulse_stop();
    go(6'd1, 1'b0);
    cyc(1);
    chk("t9_e0_new_pitch", 32'(pitch_a), 25);
    pulse_stop();
    cyc(2);
    chk("final_done_a", 32'(dcnt_a), 4);
    chk("final_done_b", 32'(dcnt_b), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Programmable melody controller for the sound generator datapath.
- Holds a note table of pitch-divider values and durations in a small RAM.
- Plays the table in order and drives the sine clkgen divider (pitch_o) and a note gate (note_on).
- Durations are counted in sample ticks: one-cycle enable pulses at fs (8 kHz) from the fs clkgen. This replaces hard-coded melody arrays.

Parameters:
- DEPTH, 32: note table entries (power of 2); AW = clog2(DEPTH).
- PW, 5: pitch field width; value = clkgen maxval, 0 = rest.
- DW, 13: duration field width, in ticks.
- GAP_TICKS, 8: silent ticks inserted after every note for articulation; 0 = legato.

Ports:
- clk  in  1  system clock (1 MHz)
- reset  in  1  synchronous, active-high
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write address
- wr_pitch  in  PW  pitch to store
- wr_dur  in  DW  duration to store
- seq_len  in  AW+1  number of notes to play; latched on start
- loop  in  1  1 = restart at entry 0 after the last note; sampled at end of each last note
- start  in  1  one-cycle start request
- stop  in  1  one-cycle abort request
- tick  in  1  sample-rate enable pulse
- pitch_o  out  PW  maxval for sine clkgen; holds last played value
- note_on  out  1  gate: 1 while a non-rest note sounds
- note_idx  out  AW  index of current entry
- busy  out  1  1 in any state except IDLE
- done  out  1  one-cycle pulse when a non-looping sequence finishes

Behaviour:
- Reset (sync, highest priority, also mid-play): state=IDLE; pitch_o=0, note_on=0, note_idx=0, busy=0, done=0; counters=0. Table contents are not cleared.
- Table: synchronous write; registered read, 1-cycle latency. On a same-cycle write and read of the same address, the read returns old data.
- Writes are accepted in every state. Writes to the playing entry take effect on its next fetch.
- States: IDLE, FETCH, PLAY, GAP.
- IDLE:
  - start=1 and seq_len>0: latch len=min(seq_len, DEPTH), idx=0, go to FETCH.
  - start with seq_len=0: ignored, no done pulse.
- FETCH (exactly 1 cycle): read entry idx. Next cycle enter PLAY with:
  - pitch_o=entry pitch
  - note_on=(pitch!=0)
  - dur_cnt=0
  - eff_dur=max(dur,1)
- PLAY:
  - On tick: dur_cnt++.
  - When a tick arrives with dur_cnt==eff_dur-1: note_on<=0 in that cycle's update, then go to GAP if GAP_TICKS>0, else advance.
  - Ticks in the FETCH cycle are ignored.
- GAP: note_on=0, pitch_o held. Count GAP_TICKS ticks, then advance.
- Advance:
  - idx<len-1: idx++, go to FETCH.
  - idx==len-1 and loop=1: idx=0, go to FETCH.
  - Otherwise: done=1 for one cycle, go to IDLE.
- stop (any non-IDLE state): next cycle IDLE, note_on=0, no done pulse.
- Same-cycle stop and start: stop wins.
- start while busy: ignored.
- note_idx mirrors idx.
- Counters are DW bits wide, so eff_dur up to 2^DW-1 ticks.

Optional Feature:
- Macro: SEQ_TEMPO_EN.
- Defined: adds input tempo_shift [1:0]. eff_dur = max(dur,1) << tempo_shift, evaluated at FETCH. Counter widens to DW+3 bits. GAP length is unscaled.
- Undefined: no port; tempo fixed at 1x.

Test Plan:
- Write 3 entries {(18,4),(13,2),(0,3)}, GAP_TICKS=0, seq_len=3, loop=0, start, tick every 4 clk.
  - pitch_o 18 with note_on=1 for 4 ticks, then 13 with note_on=1 for 2 ticks, then 0 with note_on=0 for 3 ticks.
  - done pulses once; busy falls with done.
- Same table, GAP_TICKS=2, loop=1: sequence repeats indefinitely with 2 silent ticks after each note; note_idx wraps 2->0; done never asserts.
- Entry with dur=0: plays for exactly 1 tick.
- seq_len=0 start: stays IDLE, busy=0.
- seq_len=40 with DEPTH=32: plays 32 entries.
- stop pulsed mid-note at tick 2 of 4: next cycle busy=0, note_on=0, done=0.
- stop and start in the same cycle while playing: IDLE.
- Reset asserted during GAP: all outputs 0 next cycle.
- Table contents intact afterwards: a fresh start replays entry 0.
- Write entry 1 to (20,1) while entry 0 plays; write to entry 0 on its own FETCH cycle.
  - Entry 1 plays as 20.
  - Entry 0 plays with its old value.
